serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_fs.sv | 16 +
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and the default datapath width.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor: x - y - bin, producing a difference bit and a borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow of one bit position.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit per clock,
// behind a start/ready/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [WIDTH-1:0]   part;
  logic [WIDTH-1:0]   part_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               bff;
  logic               d_bit;
  logic               b_out;
  logic               last;

  full_subtractor u_fs (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (bff),
    .d    (d_bit),
    .bout (b_out)
  );

  // Partial result with the current difference bit shifted in at the MSB,
  // and detection of the final bit position.
  always_comb begin
    part_nxt = {d_bit, part[WIDTH-1:1]};
    last     = (cnt == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, serial shifting, and result registers that only update
  // on the last RUN edge so the previous result holds until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      part   <= '0;
      cnt    <= '0;
      bff    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            part <= '0;
            cnt  <= '0;
            bff  <= 1'b0;
          end
        end
        ST_RUN: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          part <= part_nxt;
          bff  <= b_out;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            diff   <= part_nxt;
            borrow <= b_out;
            zero   <= (part_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done, borrow, zero;
  logic [W-1:0] diff;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t prev;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction with wrap-around.
  function automatic exp_t ref_sub(input int x, input int y);
    exp_t e;
    int   r;
    r = x - y;
    if (r < 0) r = r + (1 << W);
    e.d = r[W-1:0];
    e.b = (x < y);
    e.z = (r == 0);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", diff, e.d);
        chk("borrow", borrow, e.b);
        chk("zero", zero, e.z);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) chk("ready_timeout", 0, 1);
  endtask

  // Issue one operation and check the cycle-accurate handshake timing.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    wait_ready();
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    e = ref_sub(int'(x), int'(y));
    sb.push_back(e);
    #1 start = 1'b0;
    a = $urandom; b = $urandom;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      if (i == W / 2) chk("diff_hold_run", diff, prev.d);
    end
    @(negedge clk);
    chk("done_latency", done, 1);
    chk("busy_in_done", busy, 0);
    chk("ready_in_done", ready, 0);
    @(posedge clk); #1;
    chk("ready_after", ready, 1);
    prev = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   n;
    prev.d = '0; prev.b = 1'b0; prev.z = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_zero", zero, 0);
    @(posedge clk); #1;

    // Directed cases
    do_op(8'h5A, 8'h3C);
    do_op(8'h10, 8'h20);
    do_op(8'h00, 8'h01);
    do_op(8'hFF, 8'h00);
    do_op(8'h77, 8'h77);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hold_diff", diff, 0);
    chk("hold_zero", zero, 1);
    chk("hold_borrow", borrow, 0);
    @(posedge clk); #1;

    // Start pulses during RUN and DONE must be ignored
    wait_ready();
    a = 8'h40; b = 8'h01; start = 1'b1;
    @(posedge clk);
    sb.push_back(ref_sub(8'h40, 8'h01));
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 a = 8'h00; b = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignored_busy", busy, 0);
    chk("ignored_ready", ready, 1);
    chk("ignored_diff", diff, 8'h3F);
    prev = ref_sub(8'h40, 8'h01);
    @(posedge clk); #1;

    // Reset in the 4th RUN cycle aborts the operation
    wait_ready();
    a = 8'h80; b = 8'h01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    chk("abort_zero", zero, 0);
    prev.d = '0; prev.b = 1'b0; prev.z = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    do_op(8'h09, 8'h04);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      do_op(W'($urandom), W'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_subtractor
